// File: rtl/boot_ctrl.sv
// Boot sequencer: streams a program into instruction memory, runs the CPU for
// a bounded number of cycles, then reads back the first data-memory words.
module boot_ctrl #(
  parameter int IM_AW      = 10,
  parameter int DM_AW      = 10,
  parameter int DW         = 32,
  parameter int RUN_CYCLES = 260,
  parameter int DUMP_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_valid,
  input  logic [DW-1:0]    ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             im_enable,
  output logic             im_write,
  output logic [IM_AW-1:0] im_addr,
  output logic [DW-1:0]    im_wdata,
  output logic             cpu_rst,
  input  logic             halt,
  output logic             dm_sel,
  output logic             dm_enable,
  output logic             dm_read,
  output logic [DM_AW-1:0] dm_addr,
  input  logic [DW-1:0]    dm_rdata,
  output logic             dump_valid,
  output logic [DM_AW-1:0] dump_addr,
  output logic [DW-1:0]    dump_data,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);

  localparam int RCW = $clog2(RUN_CYCLES + 1);
  localparam int DCW = $clog2(DUMP_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IM_AW-1:0] ld_addr_q, ld_addr_d;
  logic             err_ovf_q, err_ovf_d;
  logic [RCW-1:0]   run_cnt_q, run_cnt_d;
  logic [DCW-1:0]   dump_cnt_q, dump_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ld_addr_q  <= '0;
      err_ovf_q  <= 1'b0;
      run_cnt_q  <= '0;
      dump_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      err_ovf_q  <= err_ovf_d;
      run_cnt_q  <= run_cnt_d;
      dump_cnt_q <= dump_cnt_d;
    end
  end

  assign err_ovf = err_ovf_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    ld_addr_d  = ld_addr_q;
    err_ovf_d  = err_ovf_q;
    run_cnt_d  = run_cnt_q;
    dump_cnt_d = dump_cnt_q;
    ld_ready   = 1'b0;
    im_enable  = 1'b0;
    im_write   = 1'b0;
    im_addr    = '0;
    im_wdata   = '0;
    cpu_rst    = 1'b1;
    dm_sel     = 1'b0;
    dm_enable  = 1'b0;
    dm_read    = 1'b0;
    dm_addr    = '0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          err_ovf_d = 1'b0;
        end
      end

      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        im_addr  = ld_addr_q;
        if (ld_valid) begin
          im_enable = 1'b1;
          im_write  = 1'b1;
          im_wdata  = ld_data;
          run_cnt_d = '0;
          // The top address is written but never wrapped past.
          if (ld_last) begin
            state_d = S_RUN;
          end else if (ld_addr_q == '1) begin
            err_ovf_d = 1'b1;
            state_d   = S_RUN;
          end else begin
            ld_addr_d = ld_addr_q + IM_AW'(1);
          end
        end
      end

      S_RUN: begin
        busy    = 1'b1;
        cpu_rst = 1'b0;
        if (halt || run_cnt_q == RCW'(RUN_CYCLES - 1)) begin
          state_d    = S_DUMP;
          dump_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + RCW'(1);
        end
      end

      S_DUMP: begin
        busy   = 1'b1;
        dm_sel = 1'b1;
        if (dump_cnt_q < DCW'(DUMP_WORDS)) begin
          dm_enable = 1'b1;
          dm_read   = 1'b1;
          dm_addr   = DM_AW'(dump_cnt_q);
        end
        // Read data returns one cycle after its address was issued.
        if (dump_cnt_q != '0) begin
          dump_valid = 1'b1;
          dump_addr  = DM_AW'(dump_cnt_q - DCW'(1));
          dump_data  = dm_rdata;
        end
        if (dump_cnt_q == DCW'(DUMP_WORDS)) begin
          state_d = S_DONE;
        end else begin
          dump_cnt_d = dump_cnt_q + DCW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
